if_fetch: RTL and testbench

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the program counter and issues single-outstanding fetch requests to instruction memory over a req/gnt/rvalid handshake. Returned words go into a 2-entry {pc, inst} buffer whose head drives `if_pc`/`if_inst`. It also handles branch and flush redirects, and raises a stall request whenever no instruction is ready.

---
 rtl/if_fetch_pkg.sv | 20 ++
 rtl/if_fetch_buf.sv | 48 ++++
 rtl/if_fetch.sv | 125 ++++++++++++
 tb/tb_if_fetch.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared bus widths, constants and fetch FSM encodings for the instruction-fetch stage.
package if_fetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    localparam logic [INST_W-1:0] ZERO_WORD = '0;
    localparam logic              STOP      = 1'b1;
    localparam logic              NO_STOP   = 1'b0;

    localparam logic [1:0] IF_IDLE = 2'd0;
    localparam logic [1:0] IF_REQ  = 2'd1;
    localparam logic [1:0] IF_WAIT = 2'd2;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_buf.sv
// Two-entry {pc, inst} FIFO between instruction memory and IF/ID; clear beats push.
module fetch_buf
    import if_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_clear,
    input  fetch_entry_t i_entry,
    output logic [1:0]   o_count,
    output fetch_entry_t o_head
);

    fetch_entry_t r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_clear) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) r_wr_ptr <= ~r_wr_ptr;
            if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else if (i_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, issues single-outstanding req/gnt/rvalid fetches,
// buffers up to two returned words and handles branch/flush redirects.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    output logic        iram_req_o,
    output logic [31:0] iram_addr_o,
    input  logic        iram_gnt_i,
    input  logic        iram_rvalid_i,
    input  logic [31:0] iram_rdata_i,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stallreq_if
);

    logic [1:0]   r_state, w_state_nxt;
    logic [31:0]  r_req_pc, w_req_pc_nxt;
    logic [31:0]  r_fetch_pc, w_fetch_pc_nxt;
    logic         r_drop, w_drop_nxt;

    logic         w_redirect, w_push, w_pop, w_rvalid_wait, w_room, w_room_after;
    logic [31:0]  w_target;
    logic [1:0]   w_count, w_count_after;
    logic [2:0]   w_reserved;
    fetch_entry_t w_head;
    logic         w_unused;

    assign w_unused      = ^{stall[5:2], stall[0]};
    assign w_redirect    = flush_i | branch_flag_i;
    assign w_target      = flush_i ? new_pc_i : branch_target_i;
    assign w_pop         = (w_count != 2'd0) && !stall[1];
    assign w_rvalid_wait = (r_state == IF_WAIT) && iram_rvalid_i;
    assign w_push        = w_rvalid_wait && !r_drop && !w_redirect;
    // Any request in flight already owns a buffer slot.
    assign w_reserved    = {1'b0, w_count} + {2'b00, (r_state != IF_IDLE)};
    assign w_room        = w_reserved < 3'd2;
    assign w_count_after = w_count + {1'b0, w_push} - {1'b0, w_pop};
    assign w_room_after  = w_count_after < 2'd2;

    always_comb begin
        w_state_nxt    = r_state;
        w_req_pc_nxt   = r_req_pc;
        w_fetch_pc_nxt = w_redirect ? w_target : r_fetch_pc;
        w_drop_nxt     = r_drop;
        case (r_state)
            IF_IDLE: begin
                if (w_redirect) begin
                    w_state_nxt  = IF_REQ;
                    w_req_pc_nxt = w_target;
                end else if (w_room) begin
                    w_state_nxt  = IF_REQ;
                    w_req_pc_nxt = r_fetch_pc;
                end
            end
            IF_REQ: begin
                // A granted stale request must not advance the redirected PC.
                if (w_redirect) begin
                    w_drop_nxt = 1'b1;
                    if (iram_gnt_i) w_state_nxt = IF_WAIT;
                end else if (iram_gnt_i) begin
                    w_state_nxt = IF_WAIT;
                    if (!r_drop) w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                end
            end
            IF_WAIT: begin
                if (iram_rvalid_i) begin
                    w_drop_nxt = 1'b0;
                    if (w_redirect) begin
                        w_state_nxt  = IF_REQ;
                        w_req_pc_nxt = w_target;
                    end else if (w_room_after) begin
                        w_state_nxt  = IF_REQ;
                        w_req_pc_nxt = r_fetch_pc;
                    end else begin
                        w_state_nxt  = IF_IDLE;
                    end
                end else if (w_redirect) begin
                    w_drop_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IF_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IF_IDLE;
            r_req_pc   <= ZERO_WORD;
            r_fetch_pc <= RESET_PC;
            r_drop     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_req_pc   <= w_req_pc_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_drop     <= w_drop_nxt;
        end
    end

    fetch_buf u_fetch_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_redirect),
        .i_entry ({r_req_pc, iram_rdata_i}),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign iram_req_o  = (r_state == IF_REQ);
    assign iram_addr_o = r_req_pc;
    assign if_pc       = (w_count != 2'd0) ? w_head.pc   : ZERO_WORD;
    assign if_inst     = (w_count != 2'd0) ? w_head.inst : ZERO_WORD;
    assign stallreq_if = (w_count == 2'd0) ? STOP : NO_STOP;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a simple instruction-memory responder.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic        iram_req_o;
    logic [31:0] iram_addr_o;
    logic        iram_gnt_i;
    logic        iram_rvalid_i;
    logic [31:0] iram_rdata_i;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq_if;

    int total = 0;
    int bad   = 0;
    int gnt_dly = 0;
    int grant_cnt = 0;
    int inj_req = 0;
    int g0;

    if_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .flush_i         (flush_i),
        .new_pc_i        (new_pc_i),
        .iram_req_o      (iram_req_o),
        .iram_addr_o     (iram_addr_o),
        .iram_gnt_i      (iram_gnt_i),
        .iram_rvalid_i   (iram_rvalid_i),
        .iram_rdata_i    (iram_rdata_i),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .stallreq_if     (stallreq_if)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1500_0000 ^ (a ^ 32'h0000_0100);
    endfunction

    // Memory: gnt after gnt_dly waiting cycles, rvalid exactly one cycle after gnt.
    initial begin
        logic        pend;
        logic [31:0] pend_data;
        int          wait_cnt;
        int          inj_done;
        pend = 1'b0; pend_data = '0; wait_cnt = 0; inj_done = 0;
        iram_gnt_i = 1'b0; iram_rvalid_i = 1'b0; iram_rdata_i = '0;
        forever begin
            @(negedge clk);
            iram_rvalid_i = pend;
            iram_rdata_i  = pend ? pend_data : 32'h0;
            if (inj_req != inj_done) begin
                iram_rvalid_i = 1'b1;
                iram_rdata_i  = 32'hDEAD_BEEF;
                inj_done = inj_req;
            end
            pend = 1'b0;
            if (iram_req_o) begin
                if (wait_cnt >= gnt_dly) begin
                    iram_gnt_i = 1'b1;
                    pend = 1'b1;
                    pend_data = mem_word(iram_addr_o);
                    wait_cnt = 0;
                    grant_cnt++;
                end else begin
                    iram_gnt_i = 1'b0;
                    wait_cnt++;
                end
            end else begin
                iram_gnt_i = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        stall = '0; branch_flag_i = 1'b0; branch_target_i = '0;
        flush_i = 1'b0; new_pc_i = '0; gnt_dly = 0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        stall = '0; branch_flag_i = 1'b0; branch_target_i = '0;
        flush_i = 1'b0; new_pc_i = '0;
        tick(); tick();
        total++; if (iram_req_o !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", iram_req_o); end
        total++; if (iram_addr_o !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", iram_addr_o); end
        total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL reset_if_pc got=%h exp=0", if_pc); end
        total++; if (if_inst !== 32'h0) begin bad++; $display("FAIL reset_if_inst got=%h exp=0", if_inst); end
        total++; if (stallreq_if !== 1'b1) begin bad++; $display("FAIL reset_stallreq got=%b exp=1", stallreq_if); end
    endtask

    task automatic test_basic;
        do_reset();
        total++; if (iram_req_o !== 1'b0) begin bad++; $display("FAIL basic_idle_first got=%b exp=0", iram_req_o); end
        tick();
        total++; if (iram_req_o !== 1'b1) begin bad++; $display("FAIL basic_req0 got=%b exp=1", iram_req_o); end
        total++; if (iram_addr_o !== 32'h100) begin bad++; $display("FAIL basic_addr0 got=%h exp=100", iram_addr_o); end
        tick();
        total++; if (iram_req_o !== 1'b0) begin bad++; $display("FAIL basic_wait got=%b exp=0", iram_req_o); end
        tick();
        total++; if (iram_addr_o !== 32'h104 || iram_req_o !== 1'b1) begin bad++; $display("FAIL basic_addr1 got=%h/%b exp=104/1", iram_addr_o, iram_req_o); end
        total++; if (if_pc !== 32'h100) begin bad++; $display("FAIL basic_pc0 got=%h exp=100", if_pc); end
        total++; if (if_inst !== 32'h1500_0000) begin bad++; $display("FAIL basic_inst0 got=%h exp=15000000", if_inst); end
        total++; if (stallreq_if !== 1'b0) begin bad++; $display("FAIL basic_stallreq0 got=%b exp=0", stallreq_if); end
        tick();
        total++; if (stallreq_if !== 1'b1 || if_pc !== 32'h0) begin bad++; $display("FAIL basic_empty got=%b/%h exp=1/0", stallreq_if, if_pc); end
        tick();
        total++; if (if_pc !== 32'h104 || if_inst !== 32'h1500_0004) begin bad++; $display("FAIL basic_pc1 got=%h/%h exp=104/15000004", if_pc, if_inst); end
        total++; if (iram_addr_o !== 32'h108) begin bad++; $display("FAIL basic_addr2 got=%h exp=108", iram_addr_o); end
    endtask

    task automatic test_stall;
        do_reset();
        stall = 6'b000010;
        g0 = grant_cnt;
        repeat (12) tick();
        total++; if (grant_cnt - g0 !== 2) begin bad++; $display("FAIL stall_grants got=%0d exp=2", grant_cnt - g0); end
        total++; if (iram_req_o !== 1'b0) begin bad++; $display("FAIL stall_no_req got=%b exp=0", iram_req_o); end
        total++; if (if_pc !== 32'h100 || if_inst !== 32'h1500_0000) begin bad++; $display("FAIL stall_head got=%h/%h exp=100/15000000", if_pc, if_inst); end
        stall = '0;
        tick();
        total++; if (if_pc !== 32'h104 || if_inst !== 32'h1500_0004) begin bad++; $display("FAIL stall_second got=%h/%h exp=104/15000004", if_pc, if_inst); end
        tick();
        total++; if (stallreq_if !== 1'b1 || if_pc !== 32'h0) begin bad++; $display("FAIL stall_drained got=%b/%h exp=1/0", stallreq_if, if_pc); end
        total++; if (iram_req_o !== 1'b1 || iram_addr_o !== 32'h108) begin bad++; $display("FAIL stall_resume got=%b/%h exp=1/108", iram_req_o, iram_addr_o); end
    endtask

    task automatic test_flush_priority;
        do_reset();
        stall = 6'b000010;
        repeat (12) tick();
        stall = '0;
        flush_i = 1'b1; new_pc_i = 32'h800;
        branch_flag_i = 1'b1; branch_target_i = 32'h2000;
        #1;
        total++; if (if_pc !== 32'h100) begin bad++; $display("FAIL prio_head_visible got=%h exp=100", if_pc); end
        tick();
        flush_i = 1'b0; branch_flag_i = 1'b0;
        total++; if (iram_req_o !== 1'b1 || iram_addr_o !== 32'h800) begin bad++; $display("FAIL prio_addr got=%b/%h exp=1/800", iram_req_o, iram_addr_o); end
        total++; if (stallreq_if !== 1'b1 || if_pc !== 32'h0) begin bad++; $display("FAIL prio_cleared got=%b/%h exp=1/0", stallreq_if, if_pc); end
        tick(); tick();
        total++; if (if_pc !== 32'h800 || if_inst !== 32'h1500_0900) begin bad++; $display("FAIL prio_data got=%h/%h exp=800/15000900", if_pc, if_inst); end
        total++; if (iram_addr_o !== 32'h804) begin bad++; $display("FAIL prio_next got=%h exp=804", iram_addr_o); end
    endtask

    task automatic test_branch_wait;
        do_reset();
        stall = 6'b000010;
        repeat (4) tick();
        total++; if (iram_req_o !== 1'b0 || if_pc !== 32'h100) begin bad++; $display("FAIL bwait_pre got=%b/%h exp=0/100", iram_req_o, if_pc); end
        stall = '0;
        branch_flag_i = 1'b1; branch_target_i = 32'h2000;
        tick();
        branch_flag_i = 1'b0;
        total++; if (iram_req_o !== 1'b1 || iram_addr_o !== 32'h2000) begin bad++; $display("FAIL bwait_addr got=%b/%h exp=1/2000", iram_req_o, iram_addr_o); end
        total++; if (stallreq_if !== 1'b1 || if_pc !== 32'h0) begin bad++; $display("FAIL bwait_dropped got=%b/%h exp=1/0", stallreq_if, if_pc); end
        tick(); tick();
        total++; if (if_pc !== 32'h2000 || if_inst !== 32'h1500_2100) begin bad++; $display("FAIL bwait_data got=%h/%h exp=2000/15002100", if_pc, if_inst); end
        total++; if (iram_addr_o !== 32'h2004) begin bad++; $display("FAIL bwait_next got=%h exp=2004", iram_addr_o); end
    endtask

    task automatic test_gnt_delay_redirect;
        do_reset();
        gnt_dly = 3;
        tick();
        total++; if (iram_req_o !== 1'b1 || iram_addr_o !== 32'h100) begin bad++; $display("FAIL gdly_req got=%b/%h exp=1/100", iram_req_o, iram_addr_o); end
        branch_flag_i = 1'b1; branch_target_i = 32'h2000;
        tick();
        branch_flag_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (iram_req_o !== 1'b1 || iram_addr_o !== 32'h100) begin bad++; $display("FAIL gdly_hold%0d got=%b/%h exp=1/100", i, iram_req_o, iram_addr_o); end
            if (i < 2) tick();
        end
        tick();
        total++; if (iram_req_o !== 1'b0) begin bad++; $display("FAIL gdly_wait got=%b exp=0", iram_req_o); end
        tick();
        total++; if (iram_req_o !== 1'b1 || iram_addr_o !== 32'h2000) begin bad++; $display("FAIL gdly_target got=%b/%h exp=1/2000", iram_req_o, iram_addr_o); end
        total++; if (stallreq_if !== 1'b1 || if_pc !== 32'h0) begin bad++; $display("FAIL gdly_discard got=%b/%h exp=1/0", stallreq_if, if_pc); end
        gnt_dly = 0;
        tick(); tick();
        total++; if (if_pc !== 32'h2000 || if_inst !== 32'h1500_2100) begin bad++; $display("FAIL gdly_data got=%h/%h exp=2000/15002100", if_pc, if_inst); end
        total++; if (iram_addr_o !== 32'h2004) begin bad++; $display("FAIL gdly_next got=%h exp=2004", iram_addr_o); end
    endtask

    task automatic test_wrap;
        do_reset();
        flush_i = 1'b1; new_pc_i = 32'hFFFF_FFFC;
        tick();
        flush_i = 1'b0;
        total++; if (iram_addr_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr got=%h exp=fffffffc", iram_addr_o); end
        tick(); tick();
        total++; if (iram_req_o !== 1'b1 || iram_addr_o !== 32'h0) begin bad++; $display("FAIL wrap_next got=%b/%h exp=1/0", iram_req_o, iram_addr_o); end
        total++; if (if_pc !== 32'hFFFF_FFFC || if_inst !== 32'hEAFF_FEFC) begin bad++; $display("FAIL wrap_data got=%h/%h exp=fffffffc/eafffefc", if_pc, if_inst); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        stall = 6'b000010;
        repeat (4) tick();
        rst = 1'b0;
        stall = '0;
        #1;
        total++; if (iram_req_o !== 1'b0 || iram_addr_o !== 32'h0) begin bad++; $display("FAIL rmid_req got=%b/%h exp=0/0", iram_req_o, iram_addr_o); end
        total++; if (if_pc !== 32'h0 || if_inst !== 32'h0 || stallreq_if !== 1'b1) begin bad++; $display("FAIL rmid_out got=%h/%h/%b exp=0/0/1", if_pc, if_inst, stallreq_if); end
        tick();
        rst = 1'b1;
        inj_req++;
        tick();
        total++; if (iram_req_o !== 1'b1 || iram_addr_o !== 32'h100) begin bad++; $display("FAIL rmid_first got=%b/%h exp=1/100", iram_req_o, iram_addr_o); end
        total++; if (stallreq_if !== 1'b1 || if_pc !== 32'h0) begin bad++; $display("FAIL rmid_stale got=%b/%h exp=1/0", stallreq_if, if_pc); end
        tick(); tick();
        total++; if (if_pc !== 32'h100 || if_inst !== 32'h1500_0000) begin bad++; $display("FAIL rmid_data got=%h/%h exp=100/15000000", if_pc, if_inst); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_flush_priority();
        test_branch_wait();
        test_gnt_delay_redirect();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
